// File: rtl/axi_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_write_arbiter_if
// User-side handshake between the write arbiter and the shared AXI write
// master.
//   m_valid    arbiter -> master  one-cycle start pulse
//   m_aw_addr  arbiter -> master  write address (stable until completion)
//   m_w_data   arbiter -> master  write data    (stable until completion)
//   m_w_strb   arbiter -> master  byte strobes  (stable until completion)
//   m_ready    master -> arbiter  one-cycle write-complete pulse
// Modports: master = arbiter side (drives the request), slave = write master.
// ---------------------------------------------------------------------------
interface axi_write_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  m_valid;
  logic [ADDR_W-1:0]     m_aw_addr;
  logic [DATA_W-1:0]     m_w_data;
  logic [DATA_W/8-1:0]   m_w_strb;
  logic                  m_ready;

  modport master (
    output m_valid, m_aw_addr, m_w_data, m_w_strb,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_aw_addr, m_w_data, m_w_strb,
    output m_ready
  );
endinterface

// File: rtl/axi_write_arbiter.sv
// ---------------------------------------------------------------------------
// axi_write_arbiter
// Shares one AXI write master among NUM_REQ requesters with round-robin
// arbitration; one transaction in flight at a time.
// Ports:
//   ACLK, ARESET   clock (rising edge), asynchronous active-high reset
//   req_valid      per-requester request, held until req_done
//   req_addr/data/strb  flattened per-requester payload (requester i at i*W)
//   req_done       one-hot completion pulse to the winner
//   req_err        one-hot watchdog timeout pulse (0 without watchdog)
//   grant          one-hot owner of the current transaction, 0 when idle
//   busy           high whenever the FSM is not IDLE
//   m_if           master-side handshake (axi_write_arbiter_if.master)
// Optional feature: define AXI_WRITE_ARBITER_WATCHDOG_EN to abort a WAIT that
// lasts TIMEOUT cycles without m_ready (pulses req_err instead of req_done).
// ---------------------------------------------------------------------------
module axi_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] req_strb,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_err,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  axi_write_arbiter_if.master           m_if
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t              state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  done_q;
  logic [IDX_W-1:0]    gnt_idx_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic                busy_q;
  logic                m_valid_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [DATA_W-1:0]   m_data_q;
  logic [STRB_W-1:0]   m_strb_q;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W:0]      cand;
  logic [NUM_REQ-1:0]  win_oh;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic [STRB_W-1:0]   win_strb;
  logic [IDX_W-1:0]    next_ptr;
  logic                timeout_hit;

  // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ); first active requester wins.
  // cand is one bit wider so the wrap needs only a single subtraction.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_oh   = '0;
    win_addr = '0;
    win_data = '0;
    win_strb = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_oh[i] = 1'b1;
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_data  = req_data[i*DATA_W +: DATA_W];
        win_strb  = req_strb[i*STRB_W +: STRB_W];
      end
    end
  end

  // The requester that just finished drops to lowest priority.
  assign next_ptr = (gnt_idx_q == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx_q + IDX_W'(1);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
      busy_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      m_strb_q  <= '0;
    end else begin
      done_q    <= '0;
      m_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            grant_q   <= win_oh;
            gnt_idx_q <= win_idx;
            m_addr_q  <= win_addr;
            m_data_q  <= win_data;
            m_strb_q  <= win_strb;
            m_valid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // m_ready wins over a timeout landing on the same cycle.
          if (m_if.m_ready || timeout_hit) begin
            done_q   <= m_if.m_ready ? grant_q : '0;
            grant_q  <= '0;
            rr_ptr_q <= next_ptr;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef AXI_WRITE_ARBITER_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT+1);

  logic [CNT_W-1:0]   wdog_q;
  logic [NUM_REQ-1:0] err_q;

  // Counter holds the number of completed WAIT cycles; the TIMEOUT-th
  // WAIT cycle without m_ready aborts.
  assign timeout_hit = (state_q == S_WAIT) && !m_if.m_ready &&
                       (wdog_q == CNT_W'(TIMEOUT-1));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wdog_q <= '0;
      err_q  <= '0;
    end else begin
      err_q <= timeout_hit ? grant_q : '0;
      if (state_q == S_ISSUE) begin
        wdog_q <= '0;
      end else if (state_q == S_WAIT) begin
        wdog_q <= wdog_q + 1'b1;
      end
    end
  end

  assign req_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign req_err     = '0;
`endif

  assign req_done       = done_q;
  assign grant          = grant_q;
  assign busy           = busy_q;
  assign m_if.m_valid   = m_valid_q;
  assign m_if.m_aw_addr = m_addr_q;
  assign m_if.m_w_data  = m_data_q;
  assign m_if.m_w_strb  = m_strb_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_write_arbiter
// Self-checking bench for axi_write_arbiter (NUM_REQ=4, 32-bit addr/data).
// Expected transactions are queued as requests are raised and popped when
// the arbiter issues m_valid. Inputs change and outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_axi_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
`ifdef AXI_WRITE_ARBITER_WATCHDOG_EN
  localparam int TIMEOUT = 10;
`else
  localparam int TIMEOUT = 255;
`endif

  typedef struct {
    int unsigned idx;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [3:0]    req_valid;
  logic [127:0]  req_addr;
  logic [127:0]  req_data;
  logic [15:0]   req_strb;
  logic [3:0]    req_done;
  logic [3:0]    req_err;
  logic [3:0]    grant;
  logic          busy;

  logic [31:0]   ra [4];
  logic [31:0]   rd [4];
  logic [3:0]    rs [4];
  exp_t          sb [$];

  int checks = 0;
  int passed = 0;

  axi_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

  axi_write_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_strb  (req_strb),
    .req_done  (req_done),
    .req_err   (req_err),
    .grant     (grant),
    .busy      (busy),
    .m_if      (m_if)
  );

  always #5 ACLK = ~ACLK;

  task automatic set_req(input int unsigned i, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    ra[i] = a;
    rd[i] = d;
    rs[i] = s;
    req_addr[i*32 +: 32] = a;
    req_data[i*32 +: 32] = d;
    req_strb[i*4 +: 4]   = s;
  endtask

  task automatic push_exp(input int unsigned i);
    exp_t e;
    e.idx  = i;
    e.addr = ra[i];
    e.data = rd[i];
    e.strb = rs[i];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    ARESET      = 1'b1;
    req_valid   = '0;
    m_if.m_ready = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
  endtask

  // Bounded wait for the start pulse; checks the current cycle first.
  task automatic wait_issue(output bit seen, output int waited);
    seen   = 1'b0;
    waited = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_if.m_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge ACLK);
      waited++;
    end
  endtask

  // Pop the next expected transaction (or flag an empty scoreboard).
  task automatic pop_exp(output bit have, output exp_t e, output logic [3:0] g);
    have = (sb.size() > 0);
    e.idx = 0; e.addr = '0; e.data = '0; e.strb = '0;
    if (have) e = sb.pop_front();
    g = 4'b0001 << e.idx;
  endtask

  // Act as the write master: hold m_ready low for lat WAIT cycles, then
  // pulse it. Returns what was observed; requesters in clr drop req_valid
  // on the completion cycle.
  task automatic finish_txn(input int lat, input logic [3:0] clr,
                            output bit stable, output logic [3:0] done_o,
                            output logic [3:0] err_o, output logic [3:0] grant_o,
                            output logic busy_o, output logic [3:0] done_nx);
    logic [31:0] a0, d0;
    logic [3:0]  s0, g0;
    a0 = m_if.m_aw_addr; d0 = m_if.m_w_data; s0 = m_if.m_w_strb; g0 = grant;
    stable = 1'b1;
    for (int k = 0; k < lat; k++) begin
      @(negedge ACLK);
      if (m_if.m_valid !== 1'b0 || m_if.m_aw_addr !== a0 || m_if.m_w_data !== d0 ||
          m_if.m_w_strb !== s0 || grant !== g0 || busy !== 1'b1 ||
          req_done !== 4'b0 || req_err !== 4'b0)
        stable = 1'b0;
    end
    m_if.m_ready = 1'b1;
    @(negedge ACLK);
    done_o = req_done; err_o = req_err; grant_o = grant; busy_o = busy;
    m_if.m_ready = 1'b0;
    req_valid = req_valid & ~clr;
    @(negedge ACLK);
    done_nx = req_done;
  endtask

  task automatic test_reset();
    bit seen; int waited; bit have; exp_t e; logic [3:0] g;
    bit st; logic [3:0] dn, er, gr, dx; logic bz;
    ARESET = 1'b1;
    m_if.m_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++)
      set_req(i, 32'h0000_0100 * (i + 1), 32'hA5A5_0000 + i, 4'hF);
    req_valid = 4'b1111;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({grant, req_done, req_err, busy, m_if.m_valid} !== 14'b0 ||
        m_if.m_aw_addr !== 32'b0 || m_if.m_w_data !== 32'b0 || m_if.m_w_strb !== 4'b0)
      $display("FAIL reset_state: grant=%b done=%b err=%b busy=%b m_valid=%b addr=%h data=%h strb=%h, required all zero",
               grant, req_done, req_err, busy, m_if.m_valid, m_if.m_aw_addr, m_if.m_w_data, m_if.m_w_strb);
    else passed++;
    for (int unsigned i = 0; i < 4; i++) push_exp(i);
    ARESET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_issue(seen, waited);
      pop_exp(have, e, g);
      checks++;
      if (!seen || !have || grant !== g || m_if.m_aw_addr !== e.addr ||
          m_if.m_w_data !== e.data || m_if.m_w_strb !== e.strb)
        $display("FAIL reset_issue%0d: seen=%0d grant=%b addr=%h data=%h strb=%h, required grant=%b addr=%h data=%h strb=%h",
                 k, seen, grant, m_if.m_aw_addr, m_if.m_w_data, m_if.m_w_strb, g, e.addr, e.data, e.strb);
      else passed++;
      finish_txn(1, g, st, dn, er, gr, bz, dx);
      checks++;
      if ({st, dn, er, gr, bz, dx} !== {1'b1, g, 4'b0, 4'b0, 1'b0, 4'b0})
        $display("FAIL reset_done%0d: stable=%0d done=%b err=%b grant=%b busy=%b done_next=%b, required stable=1 done=%b err=0 grant=0 busy=0 done_next=0",
                 k, st, dn, er, gr, bz, dx, g);
      else passed++;
    end
  endtask

  task automatic test_single();
    bit seen; int waited; bit have; exp_t e; logic [3:0] g;
    bit st; logic [3:0] dn, er, gr, dx; logic bz;
    do_reset();
    set_req(2, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    req_valid = 4'b0100;
    push_exp(2);
    wait_issue(seen, waited);
    pop_exp(have, e, g);
    checks++;
    if (!seen || !have || grant !== g || m_if.m_aw_addr !== e.addr ||
        m_if.m_w_data !== e.data || m_if.m_w_strb !== e.strb || busy !== 1'b1)
      $display("FAIL single_issue: seen=%0d grant=%b addr=%h data=%h strb=%h busy=%b, required grant=%b addr=%h data=%h strb=%h busy=1",
               seen, grant, m_if.m_aw_addr, m_if.m_w_data, m_if.m_w_strb, busy, g, e.addr, e.data, e.strb);
    else passed++;
    finish_txn(3, 4'b0100, st, dn, er, gr, bz, dx);
    checks++;
    if ({st, dn, er, gr, bz, dx} !== {1'b1, 4'b0100, 4'b0, 4'b0, 1'b0, 4'b0})
      $display("FAIL single_done: stable=%0d done=%b err=%b grant=%b busy=%b done_next=%b, required stable=1 done=0100 err=0 grant=0 busy=0 done_next=0",
               st, dn, er, gr, bz, dx);
    else passed++;
  endtask

  task automatic test_round_robin();
    bit seen; int waited; bit have; exp_t e; logic [3:0] g;
    bit st; logic [3:0] dn, er, gr, dx; logic bz;
    do_reset();
    set_req(0, 32'h1000_0000, 32'h0101_0101, 4'h1);
    set_req(1, 32'h2000_0004, 32'h0202_0202, 4'h3);
    set_req(2, 32'h3000_0008, 32'h0303_0303, 4'hC);
    set_req(3, 32'h4000_000C, 32'h0404_0404, 4'h0);
    for (int k = 0; k < 8; k++) push_exp(k % 4);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_issue(seen, waited);
      pop_exp(have, e, g);
      checks++;
      if (!seen || !have || grant !== g || m_if.m_aw_addr !== e.addr ||
          m_if.m_w_data !== e.data || m_if.m_w_strb !== e.strb || (k > 0 && waited != 0))
        $display("FAIL rr_issue%0d: seen=%0d waited=%0d grant=%b addr=%h data=%h strb=%h, required grant=%b addr=%h data=%h strb=%h waited=0",
                 k, seen, waited, grant, m_if.m_aw_addr, m_if.m_w_data, m_if.m_w_strb, g, e.addr, e.data, e.strb);
      else passed++;
      finish_txn(1 + (k % 3), (k == 7) ? 4'b1111 : 4'b0000, st, dn, er, gr, bz, dx);
      checks++;
      if ({st, dn, er, gr, bz} !== {1'b1, g, 4'b0, 4'b0, 1'b0})
        $display("FAIL rr_done%0d: stable=%0d done=%b err=%b grant=%b busy=%b, required stable=1 done=%b err=0 grant=0 busy=0",
                 k, st, dn, er, gr, bz, g);
      else passed++;
    end
  endtask

  task automatic test_fairness();
    bit seen; int waited; bit have; exp_t e; logic [3:0] g;
    bit st; logic [3:0] dn, er, gr, dx; logic bz;
    logic [3:0] clr_seq [3];
    clr_seq[0] = 4'b0000; clr_seq[1] = 4'b1000; clr_seq[2] = 4'b0010;
    do_reset();
    req_valid = 4'b0010;
    push_exp(1);
    for (int k = 0; k < 3; k++) begin
      wait_issue(seen, waited);
      pop_exp(have, e, g);
      checks++;
      if (!seen || !have || grant !== g || m_if.m_aw_addr !== e.addr || m_if.m_w_data !== e.data)
        $display("FAIL fair_issue%0d: seen=%0d grant=%b addr=%h data=%h, required grant=%b addr=%h data=%h",
                 k, seen, grant, m_if.m_aw_addr, m_if.m_w_data, g, e.addr, e.data);
      else passed++;
      if (k == 0) begin
        req_valid[3] = 1'b1;
        push_exp(3);
        push_exp(1);
      end
      finish_txn(2, clr_seq[k], st, dn, er, gr, bz, dx);
      checks++;
      if ({st, dn, er, gr, bz} !== {1'b1, g, 4'b0, 4'b0, 1'b0})
        $display("FAIL fair_done%0d: stable=%0d done=%b err=%b grant=%b busy=%b, required stable=1 done=%b err=0 grant=0 busy=0",
                 k, st, dn, er, gr, bz, g);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bit seen; int waited; bit have; exp_t e; logic [3:0] g;
    bit st; logic [3:0] dn, er, gr, dx; logic bz;
    logic [3:0] done_seen;
    do_reset();
    set_req(1, 32'h0000_BEE0, 32'h1234_5678, 4'h5);
    req_valid = 4'b0010;
    push_exp(1);
    wait_issue(seen, waited);
    pop_exp(have, e, g);
    checks++;
    if (!seen || !have || grant !== g || m_if.m_aw_addr !== e.addr)
      $display("FAIL midrst_issue: seen=%0d grant=%b addr=%h, required grant=%b addr=%h",
               seen, grant, m_if.m_aw_addr, g, e.addr);
    else passed++;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    checks++;
    if ({grant, m_if.m_valid, busy, req_done} !== 10'b0)
      $display("FAIL midrst_async: grant=%b m_valid=%b busy=%b done=%b, required all zero",
               grant, m_if.m_valid, busy, req_done);
    else passed++;
    done_seen = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      done_seen = done_seen | req_done;
    end
    ARESET = 1'b0;
    push_exp(1);
    wait_issue(seen, waited);
    done_seen = done_seen | req_done;
    pop_exp(have, e, g);
    checks++;
    if (!seen || !have || grant !== g || m_if.m_aw_addr !== e.addr || done_seen !== 4'b0)
      $display("FAIL midrst_regrant: seen=%0d grant=%b addr=%h stray_done=%b, required grant=%b addr=%h stray_done=0000",
               seen, grant, m_if.m_aw_addr, done_seen, g, e.addr);
    else passed++;
    finish_txn(1, 4'b0010, st, dn, er, gr, bz, dx);
    checks++;
    if ({st, dn, gr, bz} !== {1'b1, 4'b0010, 4'b0, 1'b0})
      $display("FAIL midrst_done: stable=%0d done=%b grant=%b busy=%b, required stable=1 done=0010 grant=0 busy=0",
               st, dn, gr, bz);
    else passed++;
  endtask

`ifdef AXI_WRITE_ARBITER_WATCHDOG_EN
  task automatic test_watchdog();
    bit seen; int waited; bit have; exp_t e; logic [3:0] g;
    bit st; logic [3:0] dn, er, gr, dx; logic bz;
    int n;
    do_reset();
    set_req(0, 32'h0000_0A00, 32'hCAFE_0000, 4'hF);
    set_req(1, 32'h0000_0B00, 32'hCAFE_0001, 4'h8);
    req_valid = 4'b0011;
    push_exp(0);
    push_exp(1);
    wait_issue(seen, waited);
    pop_exp(have, e, g);
    checks++;
    if (!seen || !have || grant !== g || m_if.m_aw_addr !== e.addr)
      $display("FAIL wdog_issue0: seen=%0d grant=%b addr=%h, required grant=%b addr=%h",
               seen, grant, m_if.m_aw_addr, g, e.addr);
    else passed++;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge ACLK);
      n++;
      if (req_err !== 4'b0 || req_done !== 4'b0) break;
    end
    // n counts negedges from the ISSUE cycle; WAIT began one edge later.
    checks++;
    if (req_err !== 4'b0001 || req_done !== 4'b0 || (n - 1) != TIMEOUT)
      $display("FAIL wdog_timeout: err=%b done=%b cycles_in_wait=%0d, required err=0001 done=0000 cycles_in_wait=%0d",
               req_err, req_done, n - 1, TIMEOUT);
    else passed++;
    req_valid = 4'b0010;
    wait_issue(seen, waited);
    pop_exp(have, e, g);
    checks++;
    if (!seen || !have || grant !== g || m_if.m_aw_addr !== e.addr)
      $display("FAIL wdog_issue1: seen=%0d grant=%b addr=%h, required grant=%b addr=%h",
               seen, grant, m_if.m_aw_addr, g, e.addr);
    else passed++;
    finish_txn(TIMEOUT, 4'b0010, st, dn, er, gr, bz, dx);
    checks++;
    if ({st, dn, er, gr, bz} !== {1'b1, 4'b0010, 4'b0, 4'b0, 1'b0})
      $display("FAIL wdog_edge_done: stable=%0d done=%b err=%b grant=%b busy=%b, required stable=1 done=0010 err=0 grant=0 busy=0",
               st, dn, er, gr, bz);
    else passed++;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    ARESET       = 1'b1;
    req_valid    = '0;
    req_addr     = '0;
    req_data     = '0;
    req_strb     = '0;
    m_if.m_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_reset_mid();
`ifdef AXI_WRITE_ARBITER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
